// File: rtl/conv_frame_ctrl_if.sv
// Payload handshake between a bit source and conv_frame_ctrl.
// The source drives in_valid/in_bit; the controller answers with in_ready.
interface conv_frame_ctrl_if;
  logic in_valid;
  logic in_bit;
  logic in_ready;

  modport master (output in_valid, output in_bit, input in_ready);
  modport slave  (input in_valid, input in_bit, output in_ready);
endinterface

// File: rtl/conv_frame_ctrl.sv
// Frame controller feeding a convolutional encoder: FRAME_LEN payload bits, then TAIL_LEN zero flush bits.
// Define CONV_NOISE_INJ_EN to add alternating noise0/noise1 strobes every NOISE_GAP payload cycles.
module conv_frame_ctrl #(
  parameter int FRAME_LEN = 16,
  parameter int TAIL_LEN  = 2,
  parameter int NOISE_GAP = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  conv_frame_ctrl_if.slave        pay,
  output logic                    enc_in,
  output logic                    noise0,
  output logic                    noise1,
  input  logic                    decosy,
  output logic                    busy,
  output logic                    done,
  output logic                    underrun,
  output logic [7:0]              sync_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_TAIL, S_DONE} state_t;

  localparam logic [7:0] FRAME_LAST = 8'(FRAME_LEN - 1);
  localparam logic [7:0] TAIL_LAST  = (TAIL_LEN > 0) ? 8'(TAIL_LEN - 1) : 8'd0;
  localparam bit PARAMS_OK = (FRAME_LEN >= 1) && (FRAME_LEN <= 255) &&
                             (TAIL_LEN >= 0) && (NOISE_GAP >= 2) && (NOISE_GAP <= 255);

  state_t     state_q, state_d;
  logic [7:0] pay_cnt_q, pay_cnt_d;
  logic [7:0] tail_cnt_q, tail_cnt_d;
  logic [7:0] sync_cnt_q, sync_cnt_d;
  logic       enc_in_q, enc_in_d;
  logic       underrun_q, underrun_d;
  logic       start_acc;

  assign start_acc = (state_q == S_IDLE) && start;

  always_comb begin
    state_d    = state_q;
    pay_cnt_d  = pay_cnt_q;
    tail_cnt_d = tail_cnt_q;
    sync_cnt_d = sync_cnt_q;
    underrun_d = underrun_q;
    enc_in_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d    = S_DATA;
          pay_cnt_d  = 8'd0;
          tail_cnt_d = 8'd0;
          sync_cnt_d = 8'd0;
          underrun_d = 1'b0;
        end
      end
      S_DATA: begin
        // A missing bit still consumes its payload slot, sending a zero.
        enc_in_d = pay.in_valid & pay.in_bit;
        if (!pay.in_valid) underrun_d = 1'b1;
        if (pay_cnt_q == FRAME_LAST) begin
          pay_cnt_d = 8'd0;
          state_d   = (TAIL_LEN == 0) ? S_DONE : S_TAIL;
        end else begin
          pay_cnt_d = pay_cnt_q + 8'd1;
        end
      end
      S_TAIL: begin
        if (tail_cnt_q == TAIL_LAST) begin
          tail_cnt_d = 8'd0;
          state_d    = S_DONE;
        end else begin
          tail_cnt_d = tail_cnt_q + 8'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if ((state_q != S_IDLE) && decosy && (sync_cnt_q != 8'hFF))
      sync_cnt_d = sync_cnt_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pay_cnt_q  <= 8'd0;
      tail_cnt_q <= 8'd0;
      sync_cnt_q <= 8'd0;
      enc_in_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pay_cnt_q  <= pay_cnt_d;
      tail_cnt_q <= tail_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      enc_in_q   <= enc_in_d;
      underrun_q <= underrun_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) assert (PARAMS_OK);
  end

  assign pay.in_ready = (state_q == S_DATA);
  assign busy         = (state_q == S_DATA) || (state_q == S_TAIL);
  assign done         = (state_q == S_DONE);
  assign enc_in       = enc_in_q;
  assign underrun     = underrun_q;
  assign sync_cnt     = sync_cnt_q;

`ifdef CONV_NOISE_INJ_EN
  localparam logic [7:0] NOISE_LAST = 8'(NOISE_GAP - 1);

  logic [7:0] noise_cnt_q, noise_cnt_d;
  logic       noise_sel_q, noise_sel_d;
  logic       noise0_q, noise0_d;
  logic       noise1_q, noise1_d;

  always_comb begin
    noise_cnt_d = noise_cnt_q;
    noise_sel_d = noise_sel_q;
    noise0_d    = 1'b0;
    noise1_d    = 1'b0;
    if (start_acc) begin
      noise_cnt_d = 8'd0;
      noise_sel_d = 1'b0;
    end else if (state_q == S_DATA) begin
      // Strobe registers together with enc_in so it marks that same payload bit.
      if (noise_cnt_q == NOISE_LAST) begin
        noise_cnt_d = 8'd0;
        noise_sel_d = ~noise_sel_q;
        noise0_d    = ~noise_sel_q;
        noise1_d    = noise_sel_q;
      end else begin
        noise_cnt_d = noise_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      noise_cnt_q <= 8'd0;
      noise_sel_q <= 1'b0;
      noise0_q    <= 1'b0;
      noise1_q    <= 1'b0;
    end else begin
      noise_cnt_q <= noise_cnt_d;
      noise_sel_q <= noise_sel_d;
      noise0_q    <= noise0_d;
      noise1_q    <= noise1_d;
    end
  end

  assign noise0 = noise0_q;
  assign noise1 = noise1_q;
`else
  assign noise0 = 1'b0;
  assign noise1 = 1'b0;
`endif

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl: default 16-bit frame instance plus a 255-bit instance for saturation.
module tb_conv_frame_ctrl;
  logic       clock = 1'b0;
  logic       reset, start, start_l, decosy;
  logic       enc_in, noise0, noise1, busy, done, underrun;
  logic [7:0] sync_cnt;
  logic       enc_in_l, noise0_l, noise1_l, busy_l, done_l, underrun_l;
  logic [7:0] sync_cnt_l;
  int         checks = 0;
  int         errors = 0;

  conv_frame_ctrl_if pay ();
  conv_frame_ctrl_if pay_l ();

  conv_frame_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .pay(pay),
    .enc_in(enc_in), .noise0(noise0), .noise1(noise1), .decosy(decosy),
    .busy(busy), .done(done), .underrun(underrun), .sync_cnt(sync_cnt)
  );

  conv_frame_ctrl #(.FRAME_LEN(255)) dut_l (
    .clock(clock), .reset(reset), .start(start_l), .pay(pay_l),
    .enc_in(enc_in_l), .noise0(noise0_l), .noise1(noise1_l), .decosy(decosy),
    .busy(busy_l), .done(done_l), .underrun(underrun_l), .sync_cnt(sync_cnt_l)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    chk(tag, {24'd0, obs}, {24'd0, exp});
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Noise expected on payload cycle pc (1-based) with NOISE_GAP = 5, as {noise0, noise1}.
  function automatic logic [1:0] exp_noise(input int pc);
    logic [1:0] r;
    r = 2'b00;
`ifdef CONV_NOISE_INJ_EN
    if (pc % 5 == 0) r = ((pc / 5) % 2 == 1) ? 2'b10 : 2'b01;
`endif
    return r;
  endfunction

  task automatic run_frame(input logic [15:0] pat, input int drop_at, input int glitch_at,
                           input logic dec);
    logic exp_bit;
    start = 1'b1;
    decosy = dec;
    tick;
    start = 1'b0;
    chk1("start_busy", busy, 1'b1);
    chk1("start_ready", pay.in_ready, 1'b1);
    chk8("start_sync_clr", sync_cnt, 8'd0);
    chk1("start_underrun_clr", underrun, 1'b0);
    for (int i = 0; i < 16; i++) begin
      pay.in_valid = (i != drop_at);
      pay.in_bit   = pat[15-i];
      start        = (i == glitch_at);
      tick;
      start   = 1'b0;
      exp_bit = (i != drop_at) ? pat[15-i] : 1'b0;
      chk1("enc_in", enc_in, exp_bit);
      chk("noise", {30'd0, noise0, noise1}, {30'd0, exp_noise(i + 1)});
      chk1("underrun", underrun, (drop_at >= 0) && (i >= drop_at));
      chk1("done_early", done, 1'b0);
    end
    pay.in_valid = 1'b0;
    chk1("tail_ready", pay.in_ready, 1'b0);
    chk1("tail_busy", busy, 1'b1);
    tick;
    chk1("tail_enc", enc_in, 1'b0);
    chk1("tail_done", done, 1'b0);
    chk("tail_noise", {30'd0, noise0, noise1}, 32'd0);
    tick;
    chk1("done_pulse", done, 1'b1);
    chk1("done_busy", busy, 1'b0);
    chk1("done_enc", enc_in, 1'b0);
    chk("done_noise", {30'd0, noise0, noise1}, 32'd0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk1("after_done", done, 1'b0);
    chk1("done_start_dropped", busy, 1'b0);
    chk8("frame_sync_cnt", sync_cnt, dec ? 8'd19 : 8'd0);
    tick;
    chk1("idle_stays", busy, 1'b0);
  endtask

  initial begin
    int  cyc;
    logic seen_done;
    reset = 1'b1; start = 1'b0; start_l = 1'b0; decosy = 1'b0;
    pay.in_valid = 1'b0; pay.in_bit = 1'b0;
    pay_l.in_valid = 1'b0; pay_l.in_bit = 1'b0;
    tick;
    tick;
    chk1("rst_enc", enc_in, 1'b0);
    chk1("rst_noise0", noise0, 1'b0);
    chk1("rst_noise1", noise1, 1'b0);
    chk1("rst_ready", pay.in_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_underrun", underrun, 1'b0);
    chk8("rst_sync", sync_cnt, 8'd0);

    // start together with reset: reset wins
    start = 1'b1;
    tick;
    start = 1'b0;
    reset = 1'b0;
    chk1("rst_start_busy", busy, 1'b0);
    tick;
    chk1("rst_start_idle", busy, 1'b0);

    run_frame(16'hB2E5, -1, -1, 1'b1);
    chk1("f1_underrun", underrun, 1'b0);

    run_frame(16'hFFFF, 4, 7, 1'b0);
    chk1("f2_underrun_hold", underrun, 1'b1);

    run_frame(16'h4C3A, -1, -1, 1'b0);
    chk1("f3_underrun", underrun, 1'b0);

    // Mid-frame reset on payload cycle 8
    decosy = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      pay.in_valid = (i != 2);
      pay.in_bit   = 1'b1;
      tick;
    end
    chk1("abort_pre_underrun", underrun, 1'b1);
    chk1("abort_pre_busy", busy, 1'b1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    pay.in_valid = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_ready", pay.in_ready, 1'b0);
    chk1("abort_enc", enc_in, 1'b0);
    chk1("abort_underrun", underrun, 1'b0);
    chk8("abort_sync", sync_cnt, 8'd0);
    chk1("abort_done", done, 1'b0);
    seen_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (done || busy) seen_done = 1'b1;
    end
    chk1("abort_no_done", seen_done, 1'b0);
    chk8("idle_sync_hold", sync_cnt, 8'd0);

    // Long frame on the 255-bit instance: sync_cnt saturation
    start_l = 1'b1;
    tick;
    start_l = 1'b0;
    pay_l.in_valid = 1'b1;
    cyc = 1;
    while (!done_l && cyc < 400) begin
      tick;
      cyc++;
    end
    chk("long_done_cycle", cyc, 32'd258);
    chk8("long_sync_sat", sync_cnt_l, 8'd255);
    chk1("long_underrun", underrun_l, 1'b0);
    tick;
    pay_l.in_valid = 1'b0;
    chk8("long_sync_hold", sync_cnt_l, 8'd255);
    chk1("long_idle", busy_l, 1'b0);
    start_l = 1'b1;
    tick;
    start_l = 1'b0;
    chk8("long_sync_clr", sync_cnt_l, 8'd0);
    chk1("long_restart_busy", busy_l, 1'b1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk1("long_reset_busy", busy_l, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_frame_ctrl.md
CONV_FRAME_CTRL -- requirements
Module: conv_frame_ctrl

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 16, giving the number of payload bits per frame (legal range 1..255).
REQ-002 The block SHALL have parameter TAIL_LEN, default 2, giving the number of zero flush bits (encoder constraint length minus one).
REQ-003 The block SHALL have parameter NOISE_GAP, default 5, giving the payload cycles between noise pulses (legal range 2..255).
REQ-004 The block SHALL have the port `clock`  input  1  sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have the port `reset`  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have the port `start`  input  1  one-cycle request to begin a frame; honoured only in IDLE.
REQ-007 The block SHALL have the port `in_valid`  input  1  payload bit available.
REQ-008 The block SHALL have the port `in_bit`  input  1  payload bit.
REQ-009 The block SHALL have the port `in_ready`  output  1  controller accepts in_bit this cycle.
REQ-010 The block SHALL have the port `enc_in`  output  1  registered bit driven to the encoder `in` port.
REQ-011 The block SHALL have the ports `noise0` and `noise1`  output  1 each  registered noise strobes to the encoder.
REQ-012 The block SHALL have the port `decosy`  input  1  encoder sync/status flag, sampled every cycle.
REQ-013 The block SHALL have the port `busy`  output  1  high in DATA and TAIL.
REQ-014 The block SHALL have the port `done`  output  1  one-cycle pulse on frame completion.
REQ-015 The block SHALL have the port `underrun`  output  1  sticky flag: a payload bit was missing during DATA.
REQ-016 The block SHALL have the port `sync_cnt`  output  8  count of frame cycles with decosy high.

Function
REQ-017 The FSM SHALL have the states IDLE, DATA, TAIL and DONE, and SHALL go IDLE->DATA on start, DATA->TAIL after FRAME_LEN payload cycles, TAIL->DONE after TAIL_LEN cycles, and DONE->IDLE unconditionally after one cycle.
REQ-018 in_ready SHALL be high only in DATA, so that a bit is accepted when in_valid and in_ready are both high.
REQ-019 Each DATA cycle SHALL count as one payload cycle: on acceptance enc_in <= in_bit; if in_valid is low, enc_in <= 0 and underrun sets.
REQ-020 The payload counter SHALL be 8-bit, cleared on entry to DATA, and SHALL cause the transition to TAIL on the cycle it reaches FRAME_LEN-1.
REQ-021 In TAIL, enc_in SHALL be 0 and in_ready SHALL be 0; in IDLE and DONE, enc_in SHALL be 0.
REQ-022 enc_in SHALL change one cycle after the acceptance edge, giving a latency of 1 from in_bit to enc_in.
REQ-023 done SHALL be high for exactly the DONE cycle, and busy SHALL be low in IDLE and DONE.
REQ-024 sync_cnt SHALL clear on the cycle start is accepted, SHALL increment in DATA/TAIL/DONE when decosy=1, and SHALL saturate at 255 (no wrap).
REQ-025 underrun SHALL clear on start acceptance and SHALL otherwise hold until reset.
REQ-026 start SHALL be ignored while busy or in DONE; a start coincident with the DONE cycle SHALL be dropped.
REQ-027 When start and reset are high in the same cycle, reset SHALL win.

Reset
REQ-028 When reset is high at a clock edge, the next state SHALL be IDLE, with enc_in=0, noise0=0, noise1=0, in_ready=0, busy=0, done=0, underrun=0, sync_cnt=0, and all counters 0.
REQ-029 A reset asserted mid-frame SHALL abort the frame with no done pulse and no tail bits.

Configuration
REQ-030 With `CONV_NOISE_INJ_EN` defined, a noise counter (cleared on DATA entry) SHALL pulse one noise strobe for one cycle on every NOISE_GAP-th payload cycle, alternating noise0 and noise1 (noise0 first).
REQ-031 Noise strobes SHALL be aligned with the enc_in bit of that payload cycle, and SHALL never be asserted in TAIL/DONE/IDLE.
REQ-032 Without `CONV_NOISE_INJ_EN`, noise0 and noise1 SHALL be constant 0 and the noise counter logic SHALL be absent.

Verification
REQ-033 Reset, then start with FRAME_LEN=16 and in_valid held high on bits 1,0,1,1,... -> enc_in reproduces the sequence one cycle later, followed by 2 zeros, done pulses once at cycle 1+16+2 after start, and underrun=0.
REQ-034 Drop in_valid on payload cycle 5 -> enc_in=0 for that bit, the frame length is unchanged (16+2), and underrun=1 until the next start.
REQ-035 Assert reset at payload cycle 8 -> next cycle is IDLE, all outputs 0, and no done pulse.
REQ-036 Hold decosy=1 for a 255-cycle FRAME_LEN frame -> sync_cnt saturates at 255; the next start clears it to 0.
REQ-037 With CONV_NOISE_INJ_EN defined and NOISE_GAP=5 -> noise0 high on payload cycle 5, noise1 on 10, noise0 on 15, nothing in TAIL; without the macro, both noise outputs stay 0.
REQ-038 Pulse start during DATA and during DONE -> ignored, and the frame count and timing are unchanged.
